sram_oq_write_ctrl: RTL

Write-side controller for the SRAM output queues, directly downstream of the output-queue arbiter. Each arbiter word (data, queue_id, valid) goes into a per-queue circular region of external SRAM. The block tracks per-queue tail, packet start and occupancy. A packet that overflows its region is rolled back and dropped whole. Per-queue packet-available flags go to the read-side scheduler.

---
 rtl/sram_oq_pkg.sv | 20 ++
 rtl/sram_oq_queue_ctx.sv | 113 +++++++++++
 rtl/sram_oq_write_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sram_oq_pkg.sv
// Shared definitions for the SRAM output-queue write controller: word layout,
// per-queue mode encoding and statistics counter width.
package sram_oq_pkg;

    localparam int EOP_BIT        = 0;
    localparam int WORD_WIDTH_DEF = 202;
    localparam int STAT_W         = 32;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_WRITE = 2'd1,
        MODE_DROP  = 2'd2
    } oq_mode_e;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sram_oq_queue_ctx.sv
// Per-queue write context: tail, packet start, occupancy, committed packet
// count and IDLE/WRITE/DROP mode, including overflow rollback of a partial packet.
module sram_oq_queue_ctx
    import sram_oq_pkg::*;
#(
    parameter int REGION_LOG2 = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_i,
    input  logic                   eop_i,
    input  logic                   deq_i,
    input  logic                   deq_eop_i,
    output logic                   wr_en_o,
    output logic [REGION_LOG2-1:0] wr_off_o,
    output logic                   pkt_avail_o,
    output logic                   q_full_o,
    output logic                   drop_o
);

    localparam logic [REGION_LOG2:0] FULL = {1'b1, {REGION_LOG2{1'b0}}};

    oq_mode_e               mode_q, mode_d;
    logic [REGION_LOG2-1:0] tail_q, tail_d;
    logic [REGION_LOG2-1:0] pkt_start_q, pkt_start_d;
    logic [REGION_LOG2:0]   occ_q, occ_d;
    logic [REGION_LOG2:0]   pkt_cnt_q, pkt_cnt_d;
    logic                   pkt_avail_q, q_full_q, drop_q;
    logic                   drop_d;
    logic                   full;
    logic [REGION_LOG2-1:0] partial_len;
    logic [REGION_LOG2:0]   occ_w, pkt_cnt_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_IDLE;
            tail_q      <= '0;
            pkt_start_q <= '0;
            occ_q       <= '0;
            pkt_cnt_q   <= '0;
            pkt_avail_q <= 1'b0;
            q_full_q    <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            tail_q      <= tail_d;
            pkt_start_q <= pkt_start_d;
            occ_q       <= occ_d;
            pkt_cnt_q   <= pkt_cnt_d;
            pkt_avail_q <= (pkt_cnt_d != '0);
            q_full_q    <= (occ_d == FULL);
            drop_q      <= drop_d;
        end
    end

    // The full test deliberately uses the pre-update occupancy: a same-cycle
    // dequeue only makes room for subsequent words.
    always_comb begin
        mode_d      = mode_q;
        tail_d      = tail_q;
        pkt_start_d = pkt_start_q;
        drop_d      = 1'b0;
        wr_en_o     = 1'b0;
        full        = (occ_q == FULL);
        partial_len = tail_q - pkt_start_q;
        occ_w       = occ_q;
        pkt_cnt_w   = pkt_cnt_q;

        if (wr_i) begin
            case (mode_q)
                MODE_DROP: begin
                    if (eop_i) begin
                        mode_d = MODE_IDLE;
                        drop_d = 1'b1;
                    end
                end
                default: begin
                    if (!full) begin
                        wr_en_o = 1'b1;
                        tail_d  = tail_q + 1'b1;
                        occ_w   = occ_q + 1'b1;
                        if (eop_i) begin
                            pkt_cnt_w   = pkt_cnt_q + 1'b1;
                            pkt_start_d = tail_q + 1'b1;
                            mode_d      = MODE_IDLE;
                        end else begin
                            mode_d = MODE_WRITE;
                        end
                    end else begin
                        tail_d = pkt_start_q;
                        occ_w  = occ_q - {1'b0, partial_len};
                        if (eop_i) begin
                            drop_d = 1'b1;
                            mode_d = MODE_IDLE;
                        end else begin
                            mode_d = MODE_DROP;
                        end
                    end
                end
            endcase
        end

        // Popping an empty queue is a caller error; hold at zero instead of wrapping.
        occ_d     = (deq_i && occ_w != '0) ? occ_w - 1'b1 : occ_w;
        pkt_cnt_d = (deq_i && deq_eop_i && pkt_cnt_w != '0) ? pkt_cnt_w - 1'b1 : pkt_cnt_w;
    end

    assign wr_off_o    = tail_q;
    assign pkt_avail_o = pkt_avail_q;
    assign q_full_o    = q_full_q;
    assign drop_o      = drop_q;

endmodule

// File: rtl/sram_oq_write_ctrl.sv
// Write-side controller for the SRAM output queues: decodes arbiter words per
// queue, registers the SRAM write port. Optional per-queue stats: SRAM_OQ_STATS_EN.
module sram_oq_write_ctrl
    import sram_oq_pkg::*;
#(
    parameter int WORD_WIDTH     = WORD_WIDTH_DEF,
    parameter int NUM_QUEUES     = 5,
    parameter int QUEUE_ID_WIDTH = 3,
    parameter int REGION_LOG2    = 16,
    parameter int ADDR_WIDTH     = 19
) (
    input  logic                      memclk,
    input  logic                      reset_n,
    input  logic [WORD_WIDTH-1:0]     din,
    input  logic                      din_valid,
    input  logic [QUEUE_ID_WIDTH-1:0] queue_id,
    input  logic                      deq_en,
    input  logic [QUEUE_ID_WIDTH-1:0] deq_queue,
    input  logic                      deq_eop,
    output logic                      sram_wr_en,
    output logic [ADDR_WIDTH-1:0]     sram_wr_addr,
    output logic [WORD_WIDTH-1:0]     sram_wr_data,
    output logic [NUM_QUEUES-1:0]     pkt_avail,
    output logic [NUM_QUEUES-1:0]     q_full,
    output logic [NUM_QUEUES-1:0]     drop_pulse
`ifdef SRAM_OQ_STATS_EN
    ,
    output logic [NUM_QUEUES*STAT_W-1:0] drop_count,
    output logic [NUM_QUEUES*STAT_W-1:0] wr_count
`endif
);

    logic                      accept;
    logic [NUM_QUEUES-1:0]     wr_sel;
    logic [NUM_QUEUES-1:0]     deq_sel;
    logic [NUM_QUEUES-1:0]     wr_en_arr;
    logic [REGION_LOG2-1:0]    tail_arr [NUM_QUEUES];
    logic [REGION_LOG2-1:0]    tail_sel;
    logic                      wr_any;
    logic [ADDR_WIDTH-1:0]     addr_d;
    logic                      wr_en_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [WORD_WIDTH-1:0]     data_q;

    // Out-of-range queue ids never match any context, so they are simply ignored.
    assign accept = din_valid && (int'(queue_id) < NUM_QUEUES);

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_q
        assign wr_sel[g]  = accept && (queue_id == QUEUE_ID_WIDTH'(g));
        assign deq_sel[g] = deq_en && (deq_queue == QUEUE_ID_WIDTH'(g));

        sram_oq_queue_ctx #(
            .REGION_LOG2(REGION_LOG2)
        ) u_ctx (
            .clk        (memclk),
            .rst_n      (reset_n),
            .wr_i       (wr_sel[g]),
            .eop_i      (din[EOP_BIT]),
            .deq_i      (deq_sel[g]),
            .deq_eop_i  (deq_eop),
            .wr_en_o    (wr_en_arr[g]),
            .wr_off_o   (tail_arr[g]),
            .pkt_avail_o(pkt_avail[g]),
            .q_full_o   (q_full[g]),
            .drop_o     (drop_pulse[g])
        );
    end

    always_comb begin
        tail_sel = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (wr_sel[q]) tail_sel = tail_arr[q];
        end
        wr_any = |wr_en_arr;
        addr_d = '0;
        addr_d[QUEUE_ID_WIDTH+REGION_LOG2-1:0] = {queue_id, tail_sel};
    end

    always_ff @(posedge memclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            wr_en_q <= wr_any;
            if (wr_any) begin
                addr_q <= addr_d;
                data_q <= din;
            end
        end
    end

    assign sram_wr_en   = wr_en_q;
    assign sram_wr_addr = addr_q;
    assign sram_wr_data = data_q;

`ifdef SRAM_OQ_STATS_EN
    logic [STAT_W-1:0] drop_cnt_q [NUM_QUEUES];
    logic [STAT_W-1:0] wr_cnt_q   [NUM_QUEUES];

    always_ff @(posedge memclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                drop_cnt_q[q] <= '0;
                wr_cnt_q[q]   <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (drop_pulse[q]) drop_cnt_q[q] <= sat_inc(drop_cnt_q[q]);
                if (wr_en_arr[q])  wr_cnt_q[q]   <= sat_inc(wr_cnt_q[q]);
            end
        end
    end

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_stats
        assign drop_count[g*STAT_W +: STAT_W] = drop_cnt_q[g];
        assign wr_count[g*STAT_W +: STAT_W]   = wr_cnt_q[g];
    end
`endif

endmodule
